// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit multiplexed seven-segment scan driver with guard, snapshot and blink
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic [3:0]  blink_mask,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;
    logic [15:0]   snap_digits_q, snap_digits_d;
    logic [3:0]    snap_dp_q, snap_dp_d;
    logic [3:0]    snap_blank_q, snap_blank_d;
    logic [3:0]    snap_blink_q, snap_blink_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frame_start_q, frame_start_d;

    logic          tick;
    logic          snap_load;
    logic [3:0]    cur_code;
    logic [6:0]    cur_pat;
    logic          cur_dark;

    always_comb begin
        tick      = (pre_q == PW'(REFRESH_DIV - 1));
        snap_load = tick && (idx_q == 2'd3);

        pre_d = tick ? '0 : pre_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;

        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_blank_d  = snap_blank_q;
        snap_blink_d  = snap_blink_q;
        fcnt_d        = fcnt_q;
        phase_d       = phase_q;
        if (snap_load) begin
            snap_digits_d = digits;
            snap_dp_d     = dp;
            snap_blank_d  = blank;
            snap_blink_d  = blink_mask;
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        frame_start_d = snap_load;

        cur_code = snap_digits_q[idx_q*4 +: 4];
        cur_dark = snap_blank_q[idx_q] | (snap_blink_q[idx_q] & phase_q);
        case (cur_code)
            4'd0:    cur_pat = 7'b1000000;
            4'd1:    cur_pat = 7'b1111001;
            4'd2:    cur_pat = 7'b0100100;
            4'd3:    cur_pat = 7'b0110000;
            4'd4:    cur_pat = 7'b0011001;
            4'd5:    cur_pat = 7'b0010010;
            4'd6:    cur_pat = 7'b0000010;
            4'd7:    cur_pat = 7'b1111000;
            4'd8:    cur_pat = 7'b0000000;
            4'd9:    cur_pat = 7'b0010000;
            default: cur_pat = 7'b0111111;
        endcase

        // Anodes stay off for the first GUARD cycles of a slot so the previous digit cannot ghost.
        an_d  = 4'b1111;
        seg_d = 8'hFF;
        if (pre_q >= PW'(GUARD)) begin
            an_d = ~(4'b0001 << idx_q);
            if (!cur_dark) begin
                seg_d = {~snap_dp_q[idx_q], cur_pat};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q         <= '0;
            idx_q         <= '0;
            fcnt_q        <= '0;
            phase_q       <= 1'b0;
            snap_digits_q <= digits;
            snap_dp_q     <= dp;
            snap_blank_q  <= blank;
            snap_blink_q  <= blink_mask;
            seg_q         <= 8'hFF;
            an_q          <= 4'b1111;
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            fcnt_q        <= fcnt_d;
            phase_q       <= phase_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_blank_q  <= snap_blank_d;
            snap_blink_q  <= snap_blink_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
